id_issue: RTL and testbench
===========================

# id_issue

Parametrised issue stage for the Tomasulo core, the successor of the plain decode/operand-select stage. It holds the architectural register file and a register status table of producer tags, and it renames each decoded instruction's destination to the reservation-station tag allocated for it. It resolves each source to either a value or a pending tag, snooping N common-data-bus (CDB) ports, and hands the result to the reservation stations through a registered valid/ready output that keeps snooping the CDB while stalled.

## Interface

Parameters:

- XLEN, 32, data width
- NREG, 32, architectural registers; x0 hardwired to zero
- TAG_W, 5, tag width; tag 0 means "ready, no producer"
- NCDB, 2, number of CDB broadcast ports
- OP_W, 10, opcode/control bundle width, passed through untouched

Ports (RW = $clog2(NREG)):

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  RW  source register indices
- in_use_rs1, in_use_rs2  in  1  source read from regfile; else immediate used
- in_imm_j, in_imm_k  in  XLEN  operand values when the source is unused
- in_rd  in  RW  destination index
- in_wr_rd  in  1  instruction writes rd
- in_tag  in  TAG_W  tag allocated by the target station; nonzero when in_valid
- in_op  in  OP_W  control bundle
- cdb_valid  in  [NCDB] 1  broadcast valid per port
- cdb_tag  in  [NCDB] TAG_W  producer tag
- cdb_data  in  [NCDB] XLEN  result
- flush  in  1  squash: clear all busy tags and the output register
- out_valid  out  1  issued instruction available
- out_ready  in  1  station accepts
- out_op  out  OP_W
- out_tag  out  TAG_W
- out_vj, out_vk  out  XLEN  operand values; valid when matching q is 0
- out_qj, out_qk  out  TAG_W  pending producer tags; 0 = operand ready

## Operation

- State: regs[NREG] XLEN, stat[NREG] TAG_W (0 = not busy), plus the output register.
- Accept: acc = in_valid && in_ready && !flush; in_ready = !out_valid || out_ready.
- Source resolution for j (k identical):
  - If !in_use_rs1: q=0, v=in_imm_j.
  - Else if rs1==0 or stat[rs1]==0: q=0, v=regs[rs1], taking cdb data if that port writes rs1 this cycle.
  - Else if a valid CDB port has tag==stat[rs1]: q=0, v=that data.
  - Else: q=stat[rs1], v=0.
- Sources see status before this instruction's own rename, so rd==rs1 reads the old producer.
- Rename: on acc && in_wr_rd && in_rd!=0, stat[in_rd] <= in_tag.
- CDB writeback: for each r!=0 with stat[r]!=0 matching a valid port tag:
  - regs[r] <= data and stat[r] <= 0.
  - If the same cycle renames r, regs still takes the data but stat takes in_tag.
  - When several ports match, the lowest port index wins; duplicate tags are illegal.
- Held output snoop: while out_valid && !out_ready, a nonzero out_qj matching a valid CDB tag sets out_vj <= data and out_qj <= 0. The same applies to k.
- Flush:
  - All stat <= 0 and out_valid <= 0; regs are kept.
  - Input is ignored that cycle, and in_ready is still driven per the formula above.
  - CDB writes in the same cycle still update regs.

## Timing

- Reset values: regs, stat, out_valid, out_op, out_tag, out_vj, out_vk, out_qj, out_qk all 0.
- Latency: accept at edge N drives out_valid from N+1.
- Throughput is 1 per cycle with out_ready held high.
- Output fields stay stable while out_valid && !out_ready, except the CDB snoop clearing q.
- A CDB broadcast on the cycle of issue is never lost: it is bypassed into the operand.
- Reset asserted mid-operation returns every register to its reset value immediately.

## Structure

- Shared package core_pkg:
  - default parameter constants
  - cdb_t struct {valid, tag, data}
  - TAG_READY = 0
- One sub-module: rstat_table, holding the stat array, rename write, CDB tag match/clear and flush.
- The regfile and operand muxes live in id_issue.

## Test plan

- Reset: after deassertion, issue add rs1=x3 rs2=x4 -> out_q* = 0, out_v* = 0, out_valid one cycle later.
- Rename + dependency: issue rd=x5 tag=7, then rs1=x5 -> second out_qj=7; CDB tag 7 data 0x1234 on the next cycle -> regs[5]=0x1234, stat[5]=0.
- Same-cycle bypass: stat[x6]=3; issue rs2=x6 while CDB port1 broadcasts tag 3 data 0xBEEF -> out_qk=0, out_vk=0xBEEF.
- Stall snoop: out_qj=9 with out_ready=0; CDB tag 9 data 0xA5 -> out_qj=0, out_vj=0xA5, other fields unchanged, in_ready=0.
- Rename vs clear: stat[x8]=4; CDB tag 4 and a rename of x8 to tag 11 in the same cycle -> stat[8]=11, regs[8]=CDB data.
- Flush and x0: flush with stat[x2]=6 and out_valid=1 -> next cycle out_valid=0 and stat[2]=0; issue rd=x0 tag=5 -> no busy bit set, reading x0 gives 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants and types for the Tomasulo core front end.
package core_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned TAG_W_DEF = 5;
  localparam int unsigned NCDB_DEF  = 2;
  localparam int unsigned OP_W_DEF  = 10;

  // Tag value meaning "operand ready, no pending producer".
  localparam logic [TAG_W_DEF-1:0] TAG_READY = '0;

  // One common-data-bus broadcast port at the default widths.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  data;
  } cdb_t;

  // Width of a CDB port index; kept at least one bit for single-port builds.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/id_issue_if.sv
// Decode-side input, CDB snoop and reservation-station output of the issue stage.
interface id_issue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned NCDB  = 2,
  parameter int unsigned OP_W  = 10
);
  localparam int unsigned RW = $clog2(NREG);

  logic                       in_valid;
  logic                       in_ready;
  logic [RW-1:0]              in_rs1;
  logic [RW-1:0]              in_rs2;
  logic                       in_use_rs1;
  logic                       in_use_rs2;
  logic [XLEN-1:0]            in_imm_j;
  logic [XLEN-1:0]            in_imm_k;
  logic [RW-1:0]              in_rd;
  logic                       in_wr_rd;
  logic [TAG_W-1:0]           in_tag;
  logic [OP_W-1:0]            in_op;

  logic [NCDB-1:0]            cdb_valid;
  logic [NCDB-1:0][TAG_W-1:0] cdb_tag;
  logic [NCDB-1:0][XLEN-1:0]  cdb_data;

  logic                       flush;

  logic                       out_valid;
  logic                       out_ready;
  logic [OP_W-1:0]            out_op;
  logic [TAG_W-1:0]           out_tag;
  logic [XLEN-1:0]            out_vj;
  logic [XLEN-1:0]            out_vk;
  logic [TAG_W-1:0]           out_qj;
  logic [TAG_W-1:0]           out_qk;

  // Decoder, CDB and reservation stations as seen from outside the stage.
  modport master (
    output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_imm_j, in_imm_k,
           in_rd, in_wr_rd, in_tag, in_op, cdb_valid, cdb_tag, cdb_data, flush, out_ready,
    input  in_ready, out_valid, out_op, out_tag, out_vj, out_vk, out_qj, out_qk
  );

  // The issue stage itself.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_imm_j, in_imm_k,
           in_rd, in_wr_rd, in_tag, in_op, cdb_valid, cdb_tag, cdb_data, flush, out_ready,
    output in_ready, out_valid, out_op, out_tag, out_vj, out_vk, out_qj, out_qk
  );

endinterface

// File: rtl/id_issue_rstat_table.sv
// Register status table: producer tag per architectural register, with rename,
// CDB tag match/clear and flush. Reports per-register CDB hits for the regfile.
module rstat_table
  import core_pkg::*;
#(
  parameter  int unsigned NREG  = 32,
  parameter  int unsigned TAG_W = 5,
  parameter  int unsigned NCDB  = 2,
  localparam int unsigned RW    = $clog2(NREG),
  localparam int unsigned SW    = sel_w(NCDB)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       ren_i,
  input  logic [RW-1:0]              ren_idx_i,
  input  logic [TAG_W-1:0]           ren_tag_i,
  input  logic [NCDB-1:0]            cdb_valid_i,
  input  logic [NCDB-1:0][TAG_W-1:0] cdb_tag_i,
  input  logic [RW-1:0]              rd_idx_j_i,
  input  logic [RW-1:0]              rd_idx_k_i,
  output logic [TAG_W-1:0]           rd_tag_j_o,
  output logic [TAG_W-1:0]           rd_tag_k_o,
  output logic [NREG-1:0]            wb_hit_o,
  output logic [NREG-1:0][SW-1:0]    wb_sel_o
);

  localparam logic [TAG_W-1:0] TagR = TAG_W'(TAG_READY);

  logic [NREG-1:0][TAG_W-1:0] stat_q, stat_d;

  // Sources read the status as it stands before this cycle's rename.
  assign rd_tag_j_o = stat_q[rd_idx_j_i];
  assign rd_tag_k_o = stat_q[rd_idx_k_i];

  // Per-register CDB match; scanning downwards lets the lowest port index win.
  always_comb begin
    wb_hit_o = '0;
    wb_sel_o = '0;
    for (int r = 1; r < int'(NREG); r++) begin
      if (stat_q[r] != TagR) begin
        for (int p = int'(NCDB) - 1; p >= 0; p--) begin
          if (cdb_valid_i[p] && (cdb_tag_i[p] == stat_q[r])) begin
            wb_hit_o[r] = 1'b1;
            wb_sel_o[r] = SW'(p);
          end
        end
      end
    end
  end

  // Next status: CDB clears, then rename overrides, flush overrides everything.
  always_comb begin
    stat_d = stat_q;
    for (int r = 1; r < int'(NREG); r++) begin
      if (wb_hit_o[r]) stat_d[r] = TagR;
    end
    if (ren_i && (ren_idx_i != '0)) stat_d[ren_idx_i] = ren_tag_i;
    if (flush_i) stat_d = '0;
    stat_d[0] = TagR;
  end

  // Status register array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

endmodule

// File: rtl/id_issue.sv
// Tomasulo issue stage: architectural regfile, rename through rstat_table,
// operand resolution with same-cycle CDB bypass, and a registered output that
// keeps snooping the CDB while stalled.
module id_issue
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned NCDB  = NCDB_DEF,
  parameter int unsigned OP_W  = OP_W_DEF
) (
  input logic        clk,
  input logic        reset,
  id_issue_if.slave  bus
);

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned SW = sel_w(NCDB);
  localparam logic [TAG_W-1:0] TagR = TAG_W'(TAG_READY);

  logic [NREG-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [NREG-1:0]            wb_hit;
  logic [NREG-1:0][SW-1:0]    wb_sel;
  logic [TAG_W-1:0]           tag_j, tag_k;

  logic                       in_ready, acc, ren;
  logic [XLEN-1:0]            vj, vk;
  logic [TAG_W-1:0]           qj, qk;

  logic                       out_valid_q;
  logic [OP_W-1:0]            out_op_q;
  logic [TAG_W-1:0]           out_tag_q, out_qj_q, out_qk_q;
  logic [XLEN-1:0]            out_vj_q, out_vk_q;

  logic                       snoop_j_hit, snoop_k_hit;
  logic [XLEN-1:0]            snoop_j_data, snoop_k_data;

  // in_ready ignores flush on purpose; flush only masks the accept.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign acc      = bus.in_valid && in_ready && !bus.flush;
  assign ren      = acc && bus.in_wr_rd && (bus.in_rd != '0);

  rstat_table #(
    .NREG  (NREG),
    .TAG_W (TAG_W),
    .NCDB  (NCDB)
  ) u_rstat (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (bus.flush),
    .ren_i       (ren),
    .ren_idx_i   (bus.in_rd),
    .ren_tag_i   (bus.in_tag),
    .cdb_valid_i (bus.cdb_valid),
    .cdb_tag_i   (bus.cdb_tag),
    .rd_idx_j_i  (bus.in_rs1),
    .rd_idx_k_i  (bus.in_rs2),
    .rd_tag_j_o  (tag_j),
    .rd_tag_k_o  (tag_k),
    .wb_hit_o    (wb_hit),
    .wb_sel_o    (wb_sel)
  );

  // Regfile writeback from the CDB; still happens on flush and on a rename of r.
  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < int'(NREG); r++) begin
      if (wb_hit[r]) regs_d[r] = bus.cdb_data[wb_sel[r]];
    end
  end

  // Regfile state; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Resolve source j: immediate, same-cycle CDB bypass, regfile value, or pending tag.
  always_comb begin
    vj = '0;
    qj = TagR;
    if (!bus.in_use_rs1) begin
      vj = bus.in_imm_j;
    end else if (wb_hit[bus.in_rs1]) begin
      vj = bus.cdb_data[wb_sel[bus.in_rs1]];
    end else if (tag_j == TagR) begin
      vj = regs_q[bus.in_rs1];
    end else begin
      qj = tag_j;
    end
  end

  // Resolve source k, same rules as j.
  always_comb begin
    vk = '0;
    qk = TagR;
    if (!bus.in_use_rs2) begin
      vk = bus.in_imm_k;
    end else if (wb_hit[bus.in_rs2]) begin
      vk = bus.cdb_data[wb_sel[bus.in_rs2]];
    end else if (tag_k == TagR) begin
      vk = regs_q[bus.in_rs2];
    end else begin
      qk = tag_k;
    end
  end

  // CDB match against the held output's pending tags, lowest port first.
  always_comb begin
    snoop_j_hit  = 1'b0;
    snoop_k_hit  = 1'b0;
    snoop_j_data = '0;
    snoop_k_data = '0;
    for (int p = int'(NCDB) - 1; p >= 0; p--) begin
      if (bus.cdb_valid[p] && (out_qj_q != TagR) && (bus.cdb_tag[p] == out_qj_q)) begin
        snoop_j_hit  = 1'b1;
        snoop_j_data = bus.cdb_data[p];
      end
      if (bus.cdb_valid[p] && (out_qk_q != TagR) && (bus.cdb_tag[p] == out_qk_q)) begin
        snoop_k_hit  = 1'b1;
        snoop_k_data = bus.cdb_data[p];
      end
    end
  end

  // Output register: load on accept, drop on consume/flush, snoop while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_tag_q   <= '0;
      out_vj_q    <= '0;
      out_vk_q    <= '0;
      out_qj_q    <= '0;
      out_qk_q    <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (acc) begin
      out_valid_q <= 1'b1;
      out_op_q    <= bus.in_op;
      out_tag_q   <= bus.in_tag;
      out_vj_q    <= vj;
      out_vk_q    <= vk;
      out_qj_q    <= qj;
      out_qk_q    <= qk;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      if (snoop_j_hit) begin
        out_vj_q <= snoop_j_data;
        out_qj_q <= TagR;
      end
      if (snoop_k_hit) begin
        out_vk_q <= snoop_k_data;
        out_qk_q <= TagR;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_vj    = out_vj_q;
  assign bus.out_vk    = out_vk_q;
  assign bus.out_qj    = out_qj_q;
  assign bus.out_qk    = out_qk_q;

endmodule

// File: tb/tb_id_issue.sv
// Self-checking bench for id_issue: directed scenarios followed by random
// traffic, all compared against a register/status-table reference model.
module tb_id_issue;
  import core_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned NCDB  = 2;
  localparam int unsigned OP_W  = 10;
  localparam int unsigned RW    = $clog2(NREG);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_issue_if #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCDB(NCDB), .OP_W(OP_W)) bus ();

  id_issue #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .TAG_W (TAG_W),
    .NCDB  (NCDB),
    .OP_W  (OP_W)
  ) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [XLEN-1:0]  m_regs [NREG];
  logic [TAG_W-1:0] m_stat [NREG];
  logic             m_ov;
  logic [OP_W-1:0]  m_op;
  logic [TAG_W-1:0] m_tag, m_qj, m_qk;
  logic [XLEN-1:0]  m_vj, m_vk;

  cdb_t cdb [NCDB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < int'(NREG); r++) begin
      m_regs[r] = '0;
      m_stat[r] = '0;
    end
    m_ov = 1'b0; m_op = '0; m_tag = '0; m_qj = '0; m_qk = '0; m_vj = '0; m_vk = '0;
  endtask

  // Lowest valid CDB port broadcasting tag t, or -1.
  function automatic int port_hit(input logic [TAG_W-1:0] t);
    if (t == '0) return -1;
    for (int p = 0; p < int'(NCDB); p++) begin
      if (cdb[p].valid && cdb[p].tag == t) return p;
    end
    return -1;
  endfunction

  task automatic resolve(input logic use_rs, input logic [RW-1:0] rs, input logic [XLEN-1:0] imm,
                         output logic [XLEN-1:0] v, output logic [TAG_W-1:0] q);
    int p;
    v = '0;
    q = '0;
    if (!use_rs) v = imm;
    else if (rs == '0) v = '0;
    else if (m_stat[rs] == '0) v = m_regs[rs];
    else begin
      p = port_hit(m_stat[rs]);
      if (p >= 0) v = cdb[p].data;
      else q = m_stat[rs];
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic             ready, acc;
    logic [XLEN-1:0]  vj, vk;
    logic [TAG_W-1:0] qj, qk;
    logic [XLEN-1:0]  nregs [NREG];
    logic [TAG_W-1:0] nstat [NREG];
    int               p;
    ready = !m_ov || bus.out_ready;
    acc   = bus.in_valid && ready && !bus.flush;
    resolve(bus.in_use_rs1, bus.in_rs1, bus.in_imm_j, vj, qj);
    resolve(bus.in_use_rs2, bus.in_rs2, bus.in_imm_k, vk, qk);
    for (int r = 0; r < int'(NREG); r++) begin
      nregs[r] = m_regs[r];
      nstat[r] = m_stat[r];
      p = port_hit(m_stat[r]);
      if (r != 0 && p >= 0) begin
        nregs[r] = cdb[p].data;
        nstat[r] = '0;
      end
    end
    if (acc && bus.in_wr_rd && bus.in_rd != '0) nstat[bus.in_rd] = bus.in_tag;
    if (bus.flush) for (int r = 0; r < int'(NREG); r++) nstat[r] = '0;
    if (bus.flush) begin
      m_ov = 1'b0;
    end else if (acc) begin
      m_ov = 1'b1; m_op = bus.in_op; m_tag = bus.in_tag;
      m_vj = vj; m_qj = qj; m_vk = vk; m_qk = qk;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end else if (m_ov) begin
      p = port_hit(m_qj);
      if (p >= 0) begin m_vj = cdb[p].data; m_qj = '0; end
      p = port_hit(m_qk);
      if (p >= 0) begin m_vk = cdb[p].data; m_qk = '0; end
    end
    for (int r = 0; r < int'(NREG); r++) begin
      m_regs[r] = nregs[r];
      m_stat[r] = nstat[r];
    end
  endtask

  task automatic apply_cdb();
    for (int p = 0; p < int'(NCDB); p++) begin
      bus.cdb_valid[p] = cdb[p].valid;
      bus.cdb_tag[p]   = cdb[p].tag;
      bus.cdb_data[p]  = cdb[p].data;
    end
  endtask

  task automatic compare();
    chk("in_ready", 32'(bus.in_ready), 32'(!m_ov || bus.out_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_op", 32'(bus.out_op), 32'(m_op));
      chk("out_tag", 32'(bus.out_tag), 32'(m_tag));
      chk("out_vj", bus.out_vj, m_vj);
      chk("out_qj", 32'(bus.out_qj), 32'(m_qj));
      chk("out_vk", bus.out_vk, m_vk);
      chk("out_qk", 32'(bus.out_qk), 32'(m_qk));
    end
  endtask

  task automatic tick();
    apply_cdb();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    for (int p = 0; p < int'(NCDB); p++) cdb[p] = '0;
  endtask

  task automatic issue(input logic [RW-1:0] rs1, input logic u1, input logic [RW-1:0] rs2,
                       input logic u2, input logic [RW-1:0] rd, input logic wr,
                       input logic [TAG_W-1:0] tag, input logic [OP_W-1:0] op);
    bus.in_valid   = 1'b1;
    bus.in_rs1     = rs1;
    bus.in_use_rs1 = u1;
    bus.in_rs2     = rs2;
    bus.in_use_rs2 = u2;
    bus.in_imm_j   = 32'h1000 + 32'(op);
    bus.in_imm_k   = 32'h2000 + 32'(op);
    bus.in_rd      = rd;
    bus.in_wr_rd   = wr;
    bus.in_tag     = tag;
    bus.in_op      = op;
  endtask

  task automatic set_cdb(input int p, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    cdb[p].valid = 1'b1;
    cdb[p].tag   = t;
    cdb[p].data  = d;
  endtask

  // Random traffic: CDB tags favour currently busy producers, never duplicated.
  task automatic rand_cycle();
    logic [TAG_W-1:0] t;
    logic             dup;
    idle();
    for (int p = 0; p < int'(NCDB); p++) begin
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 9) < 7) begin
          t = m_stat[$urandom_range(0, NREG - 1)];
          if (t == '0) t = m_qj;
          if (t == '0) t = TAG_W'($urandom_range(1, 31));
        end else begin
          t = TAG_W'($urandom_range(1, 31));
        end
        dup = 1'b0;
        for (int q = 0; q < p; q++) if (cdb[q].valid && cdb[q].tag == t) dup = 1'b1;
        if (!dup) set_cdb(p, t, $urandom);
      end
    end
    if ($urandom_range(0, 9) < 7) begin
      issue(RW'($urandom_range(0, NREG - 1)), 1'($urandom), RW'($urandom_range(0, NREG - 1)),
            1'($urandom), RW'($urandom_range(0, NREG - 1)), 1'($urandom),
            TAG_W'($urandom_range(1, 31)), OP_W'($urandom));
      bus.in_imm_j = $urandom;
      bus.in_imm_k = $urandom;
    end
    bus.out_ready = ($urandom_range(0, 9) < 7);
    bus.flush     = ($urandom_range(0, 49) == 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    issue('0, 1'b0, '0, 1'b0, '0, 1'b0, 5'd1, '0);
    idle();
    apply_cdb();
    model_reset();
    #7;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_op", 32'(bus.out_op), 32'd0);
    chk("rst_out_qj", 32'(bus.out_qj), 32'd0);
    chk("rst_out_vk", bus.out_vk, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain issue after reset.
    idle(); issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd1, 10'h011); tick();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_qj", 32'(bus.out_qj), 32'd0);
    chk("add_vk", bus.out_vk, 32'd0);

    // Rename x5 to tag 7, read it, then broadcast tag 7.
    idle(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd7, 10'h022); tick();
    idle(); issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 10'h033); tick();
    chk("dep_qj", 32'(bus.out_qj), 32'd7);
    idle(); set_cdb(0, 5'd7, 32'h1234); tick();
    idle(); issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 10'h034); tick();
    chk("wb_qj", 32'(bus.out_qj), 32'd0);
    chk("wb_vj", bus.out_vj, 32'h1234);

    // Same-cycle bypass on port 1.
    idle(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 5'd3, 10'h044); tick();
    idle(); issue(5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 5'd10, 10'h045); set_cdb(1, 5'd3, 32'hBEEF);
    tick();
    chk("byp_qk", 32'(bus.out_qk), 32'd0);
    chk("byp_vk", bus.out_vk, 32'hBEEF);

    // Stalled output snoops the CDB.
    idle(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 5'd9, 10'h055); tick();
    idle(); issue(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 10'h056); tick();
    chk("stall_qj0", 32'(bus.out_qj), 32'd9);
    idle(); bus.out_ready = 1'b0; issue(5'd1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 10'h057);
    set_cdb(0, 5'd9, 32'hA5); tick();
    chk("snoop_qj", 32'(bus.out_qj), 32'd0);
    chk("snoop_vj", bus.out_vj, 32'hA5);
    chk("snoop_tag", 32'(bus.out_tag), 32'd12);
    chk("snoop_in_ready", 32'(bus.in_ready), 32'd0);
    idle(); bus.out_ready = 1'b1; tick();

    // Rename and CDB clear of x8 in the same cycle.
    idle(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 5'd4, 10'h066); tick();
    idle(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 5'd11, 10'h067); set_cdb(0, 5'd4, 32'h4444);
    tick();
    idle(); issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 10'h068); tick();
    chk("rnclr_qj", 32'(bus.out_qj), 32'd11);

    // Flush drops the output and busy tags but keeps regs.
    idle(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 5'd6, 10'h077); tick();
    idle(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd15, 10'h078); bus.flush = 1'b1; tick();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    idle(); issue(5'd2, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd16, 10'h079); tick();
    chk("flush_qj", 32'(bus.out_qj), 32'd0);
    chk("flush_qk", 32'(bus.out_qk), 32'd0);
    chk("flush_vk", bus.out_vk, 32'h4444);

    // x0 is never renamed.
    idle(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 10'h07A); tick();
    idle(); issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd17, 10'h07B); tick();
    chk("x0_qj", 32'(bus.out_qj), 32'd0);
    chk("x0_vj", bus.out_vj, 32'd0);

    for (int i = 0; i < 600; i++) rand_cycle();

    // Reset in the middle of traffic.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_qj", 32'(bus.out_qj), 32'd0);
    chk("mid_rst_tag", 32'(bus.out_tag), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
